// File: rtl/counter_pkg.sv
// Shared types and the hex seven-segment glyph table for multi_mode_counter.
package counter_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Active-low segments, bit order gfedcba.
  localparam seg7_t SEG7_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the system clock into a square wave; o_tick marks each rising
// edge of that square wave for one system-clock cycle.
module tick_divider #(
  parameter int DIV = 25000000
) (
  input  logic i_clock_50mhz,
  input  logic i_reset,
  output logic o_sync_clock,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;
  logic          at_end;

  assign at_end = (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    sync_d = sync_q;
    if (at_end) begin
      cnt_d  = '0;
      sync_d = ~sync_q;
    end
  end

  always_ff @(posedge i_clock_50mhz) begin
    if (i_reset) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync_clock = sync_q;
  assign o_tick       = at_end & ~sync_q;

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down wrap-or-saturate counter advanced by a divided tick, with hex
// seven-segment display, LED mirror, visible sync clock and wrap pulse.
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned INITIAL   = 64'd0,
  parameter int              CLOCK_HZ  = 50000000,
  parameter int              FREQUENCY = 1,
  localparam int             DIGITS    = (WIDTH + 3) / 4
) (
  input  logic                  i_clock_50mhz,
  input  logic                  i_reset,
  input  logic                  i_set,
  input  logic                  i_pause,
  input  logic                  i_count,
  input  logic                  i_type,
  output logic [WIDTH-1:0]      o_value,
  output logic [DIGITS*7-1:0]   o_hex,
  output logic [WIDTH-1:0]      o_LEDS,
  output logic                  o_sync_clock,
  output logic                  o_wrap
);

  localparam int DIV = CLOCK_HZ / (2 * FREQUENCY);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INITIAL);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("multi_mode_counter: WIDTH must be 1..32");
  end
  if (MAX_VALUE < 64'd1 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("multi_mode_counter: MAX_VALUE out of range");
  end
  if (INITIAL > MAX_VALUE) begin : g_bad_init
    $error("multi_mode_counter: INITIAL exceeds MAX_VALUE");
  end
  if (DIV < 1) begin : g_bad_div
    $error("multi_mode_counter: CLOCK_HZ/(2*FREQUENCY) must be >= 1");
  end

  logic tick;

  tick_divider #(.DIV(DIV)) u_div (
    .i_clock_50mhz (i_clock_50mhz),
    .i_reset       (i_reset),
    .o_sync_clock  (o_sync_clock),
    .o_tick        (tick)
  );

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  dir_e             dir;
  mode_e            mode;

  assign dir  = dir_e'(i_count);
  assign mode = mode_e'(i_type);

  // Ticks arriving during set or pause are dropped, never queued.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (i_set) begin
      value_d = INIT_V;
    end else if (!i_pause && tick) begin
      if (dir == DIR_UP) begin
        if (value_q >= MAX_V) begin
          if (mode == MODE_WRAP) begin
            value_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          if (mode == MODE_WRAP) begin
            value_d = MAX_V;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock_50mhz) begin
    if (i_reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_value = value_q;
  assign o_LEDS  = value_q;
  assign o_wrap  = wrap_q;

  logic [DIGITS*4-1:0] nib_pad;
  assign nib_pad = (DIGITS*4)'(value_q);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign o_hex[7*k +: 7] = seg7_decode(nib_pad[4*k +: 4]);
  end

endmodule
